mux8_rr_sched: RTL and testbench
================================

Name: mux8_rr_sched

Overview:
- Round-robin scheduler that shares the 8:1 cascaded mux tree between eight requesters.
- Drives the three tree select levels:
  - sel[0] drives the four first-level 2:1 muxes.
  - sel[1] drives the two second-level muxes.
  - sel[2] drives the final mux.
- Waits a programmable settle time after any select change before declaring the mux output valid.
- Enforces a maximum hold time per grant.

Parameters:
- SETTLE_CYC, 2, cycles between a sel update and valid/gnt assertion (0..15; 0 = grant on the cycle after selection).
- HOLD_MAX, 8, maximum consecutive GRANT cycles per owner (1..255; 0 = unlimited).

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scheduler enable.
- req  input  8  request vector; bit i means input i of the mux wants the shared output.
- done  input  1  owner releases the grant (single-cycle pulse or level).
- sel  output  3  mux-tree select; bit0/bit1/bit2 go to level 1/2/3.
- gnt  output  8  one-hot grant; gnt[sel] is high only in GRANT.
- valid  output  1  mux output settled and owned; equals |gnt.
- preempt  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state=IDLE, sel=0, gnt=0, valid=0, preempt=0.
  - Priority pointer ptr=0; settle and hold counters=0.
  - Reset asserted mid-grant clears gnt/valid without waiting for a clock edge.
- States: IDLE, SETTLE, GRANT.
- IDLE:
  - If en=1 and req!=0, pick the first set req bit at index ptr, ptr+1, ... with modulo-8 wrap.
  - Load its index into sel at the next edge.
  - Go to SETTLE; go directly to GRANT if SETTLE_CYC=0.
  - Otherwise stay in IDLE; sel holds its last value, so no spurious mux toggling.
- SETTLE:
  - Counts SETTLE_CYC cycles with gnt=0, valid=0.
  - Abort to IDLE if req[sel]=0 or en=0; no grant is issued.
  - Otherwise enter GRANT after the final count.
- GRANT:
  - gnt=1<<sel, valid=1.
  - Hold counter starts at 1 on the first GRANT cycle and increments each cycle.
  - Release at the next edge when any of these holds:
    - req[sel]=0;
    - done=1;
    - en=0;
    - HOLD_MAX!=0 and hold counter==HOLD_MAX.
  - The HOLD_MAX case asserts preempt for one cycle, coincident with gnt/valid falling.
  - If done and a timeout occur in the same cycle, preempt=1.
- Every exit from SETTLE or GRANT:
  - ptr <= sel+1 mod 8 (7 wraps to 0), so the last owner gets lowest priority.
  - State returns to IDLE.
- Latency:
  - Request visible in IDLE at edge t → sel updated at t+1 → gnt/valid at t+1+SETTLE_CYC.
  - At least one IDLE cycle separates consecutive grants, including a re-grant to the same requester.
- req changes on non-selected bits during SETTLE/GRANT are ignored until the next IDLE.
- en=0 in IDLE blocks new grants; ptr is unchanged.
- gnt is always one-hot or zero.
- sel changes only on the IDLE→SETTLE/GRANT transition.

Test Plan:
- Reset:
  - Drive req=8'hFF, done=0 until GRANT (sel=0, gnt=8'h01).
  - Pull rst_n low between clock edges → gnt=0, valid=0, sel=0 immediately.
  - Release rst_n with req=0 → remains IDLE.
- Single request (SETTLE_CYC=2):
  - Assert req=8'h20 at edge 0 → sel=5 after edge 1; gnt=8'h20, valid=1 after edge 3.
  - Pulse done → gnt=0 after the next edge; ptr=6.
- Fairness:
  - Hold req=8'hFF, pulse done two cycles after each valid rise.
  - Grant order 0,1,2,3,4,5,6,7,0 → each index appears exactly once per 8 grants.
  - Exactly one IDLE cycle appears between grants.
- Preemption (HOLD_MAX=4):
  - Hold req=8'h44, no done → valid high exactly 4 cycles for sel=2.
  - preempt pulses once; next grant goes to sel=6.
  - Repeat with req=8'h04 only → sel=2 re-granted after 1 IDLE cycle plus settle.
- Wrap-around:
  - With ptr=1 and req=8'h81 → grant 7 first, ptr becomes 0, then grant 0.
- Settle abort:
  - req=8'h08; drop req[3] during SETTLE → no gnt, valid stays 0, state IDLE, ptr=4.
  - Simultaneously-held req[1] is granted on the next arbitration.

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin owner scheduler for a shared 8:1 cascaded mux tree.
// It picks an owner, waits for the tree to settle, then grants it for a bounded number of cycles.
module mux8_rr_sched #(
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_MAX   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       preempt,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] HOLD_LIM    = 8'(HOLD_MAX);

  state_t     state, state_nxt;
  logic [2:0] sel_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [3:0] settle_cnt, settle_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       preempt_nxt;

  logic [2:0] cand;
  logic [2:0] pick_idx;
  logic       pick_found;
  logic       timeout;
  logic       release_gnt;

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    cand       = '0;
    pick_idx   = ptr;
    pick_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign timeout     = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM);
  assign release_gnt = !req[sel] || done || !en || timeout;

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    ptr_nxt     = ptr;
    settle_nxt  = settle_cnt;
    hold_nxt    = hold_cnt;
    preempt_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (en && pick_found) begin
          sel_nxt    = pick_idx;
          settle_nxt = '0;
          hold_nxt   = 8'd1;
          state_nxt  = (SETTLE_CYC == 0) ? GRANT : SETTLE;
        end
      end
      SETTLE: begin
        if (!req[sel] || !en) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 3'd1;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = GRANT;
          hold_nxt  = 8'd1;
        end else begin
          settle_nxt = settle_cnt + 4'd1;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          state_nxt   = IDLE;
          ptr_nxt     = sel + 3'd1;
          preempt_nxt = timeout;
        end else if (hold_cnt != 8'hFF) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      ptr        <= '0;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      preempt    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      ptr        <= ptr_nxt;
      settle_cnt <= settle_nxt;
      hold_cnt   <= hold_nxt;
      preempt    <= preempt_nxt;
    end
  end

  // valid marks a settled, owned mux output; there is no ready, the owner ends its turn with done.
  assign gnt       = (state == GRANT) ? (8'd1 << sel) : 8'd0;
  assign valid     = (state == GRANT);
  assign fsm_state = state;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a turn-based owner model.
module tb_mux8_rr_sched;

  localparam int SETTLE_CYC = 2;
  localparam int HOLD_MAX   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       done = 1'b0;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic       preempt;
  logic [1:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;

  mux8_rr_sched #(.SETTLE_CYC(SETTLE_CYC), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .sel(sel), .gnt(gnt), .valid(valid), .preempt(preempt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  // model: one owner at a time; age counts cycles since its selection
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_age = 0;
  int m_ptr = 0;
  int m_sel = 0;
  bit m_pre = 1'b0;

  task automatic model_step();
    bit found;
    bit to;
    bit nxt_pre;
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_age = 0; m_ptr = 0; m_sel = 0; m_pre = 1'b0;
      return;
    end
    nxt_pre = 1'b0;
    if (!m_busy) begin
      if (en && req != 8'd0) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!found && req[(m_ptr + k) % 8]) begin
            found = 1'b1;
            m_owner = (m_ptr + k) % 8;
          end
        end
        m_sel = m_owner; m_busy = 1'b1; m_age = 0;
      end
    end else if (m_age < SETTLE_CYC) begin
      if (!req[m_owner] || !en) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % 8;
      end else m_age++;
    end else begin
      to = (HOLD_MAX != 0) && (m_age - SETTLE_CYC + 1 == HOLD_MAX);
      if (!req[m_owner] || done || !en || to) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % 8; nxt_pre = to;
      end else m_age++;
    end
    m_pre = nxt_pre;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    logic [7:0] exp_gnt;
    bit granted;
    int exp_state;
    @(negedge clk);
    granted   = m_busy && (m_age >= SETTLE_CYC);
    exp_gnt   = granted ? (8'd1 << m_owner) : 8'd0;
    exp_state = !m_busy ? 0 : (granted ? 2 : 1);
    check("sel", 32'(sel), 32'(m_sel));
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("valid", 32'(valid), 32'(granted));
    check("preempt", 32'(preempt), 32'(m_pre));
    check("state", 32'(fsm_state), 32'(exp_state));
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int lows);
    lows = 0;
    while (valid !== 1'b1 && lows < 100) begin
      tick();
      lows++;
    end
    check("wait_valid", 32'(valid), 32'd1);
  endtask

  task automatic pulse_done(input logic [7:0] next_req);
    done = 1'b1;
    req = next_req;
    tick();
    done = 1'b0;
  endtask

  task automatic hold_until_drop(output int highs);
    highs = 0;
    while (valid === 1'b1 && highs < 100) begin
      tick();
      highs++;
    end
  endtask

  initial begin
    int lows;
    int highs;
    int order[8];
    #12 rst_n = 1'b1;

    // reset mid-grant
    wait_valid(lows);
    check("rst_sel0", 32'(sel), 32'd0);
    check("rst_gnt01", 32'(gnt), 32'h01);
    #1 rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_valid", 32'(valid), 32'd0);
    check("async_sel", 32'(sel), 32'd0);
    req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_idle", 32'(fsm_state), 32'd0);
    check("post_rst_valid", 32'(valid), 32'd0);

    // single request
    req = 8'h20;
    tick();
    check("single_sel5", 32'(sel), 32'd5);
    check("single_settle", 32'(fsm_state), 32'd1);
    tick();
    check("single_nogntyet", 32'(gnt), 32'd0);
    tick();
    check("single_gnt20", 32'(gnt), 32'h20);
    check("single_valid", 32'(valid), 32'd1);
    pulse_done(8'h41);
    check("single_released", 32'(gnt), 32'd0);
    wait_valid(lows);
    check("ptr6_pick", 32'(sel), 32'd6);
    pulse_done(8'hFF);

    // fairness: ptr is 7 here
    for (int g = 0; g < 8; g++) begin
      wait_valid(lows);
      order[g] = int'(sel);
      if (g > 0) check("fair_gap", 32'(lows), 32'(1 + SETTLE_CYC));
      tick(); tick();
      pulse_done((g == 7) ? 8'h44 : 8'hFF);
    end
    for (int g = 0; g < 8; g++) check("fair_order", 32'(order[g]), 32'((7 + g) % 8));

    // preemption by hold limit
    wait_valid(lows);
    check("pre_sel2", 32'(sel), 32'd2);
    hold_until_drop(highs);
    check("pre_hold_len", 32'(highs), 32'(HOLD_MAX));
    check("pre_pulse", 32'(preempt), 32'd1);
    wait_valid(lows);
    check("pre_next6", 32'(sel), 32'd6);
    req = 8'h04;
    tick();
    wait_valid(lows);
    check("regrant_sel2", 32'(sel), 32'd2);
    hold_until_drop(highs);
    check("regrant_hold", 32'(highs), 32'(HOLD_MAX));
    check("regrant_pulse", 32'(preempt), 32'd1);
    wait_valid(lows);
    check("regrant_gap", 32'(lows), 32'(1 + SETTLE_CYC));
    check("regrant_same", 32'(sel), 32'd2);
    pulse_done(8'h01);

    // wrap-around
    wait_valid(lows);
    check("wrap_pre0", 32'(sel), 32'd0);
    pulse_done(8'h81);
    wait_valid(lows);
    check("wrap_first7", 32'(sel), 32'd7);
    pulse_done(8'h81);
    wait_valid(lows);
    check("wrap_then0", 32'(sel), 32'd0);
    pulse_done(8'h04);

    // settle abort
    wait_valid(lows);
    check("abort_setup2", 32'(sel), 32'd2);
    pulse_done(8'h0A);
    tick();
    check("abort_sel3", 32'(sel), 32'd3);
    check("abort_settling", 32'(fsm_state), 32'd1);
    req = 8'h02;
    tick();
    check("abort_idle", 32'(fsm_state), 32'd0);
    check("abort_novalid", 32'(valid), 32'd0);
    wait_valid(lows);
    check("abort_next1", 32'(sel), 32'd1);
    pulse_done(8'h00);

    // randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      en   = ($urandom_range(0, 15) != 0);
      done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rand_async_gnt", 32'(gnt), 32'd0);
        tick();
        rst_n = 1'b1;
      end
    end
    done = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
